stopwatch_core: RTL and testbench

Stopwatch timebase, BCD time counter and lap-capture register bank. Conditions the raw start and lap buttons, runs the RUN/PAUSE/IDLE control FSM, and counts hundredths of a second in four BCD digits. It produces the running-time digits, the lap-time digits and the status strobes consumed by the display multiplexer, and sits between the board buttons and that multiplexer.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/btn_conditioner.sv | 53 +++++
 rtl/stopwatch_core.sv | 154 +++++++++++++++
 tb/tb_stopwatch_core.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch core
//
// Contents:
//   sw_state_e  - control FSM state encoding (IDLE/RUN/PAUSE)
//   BCD_W       - width of one BCD digit
//   BCD_MAX     - largest legal BCD digit value
//   NUM_DIGITS  - number of time digits (tens of s, s, tenths, hundredths)
//   bcd_inc     - increment one BCD digit with 9 -> 0 wrap
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int NUM_DIGITS = 4;

  // Anything at or above 9 wraps to 0, so a digit can never leave 0..9.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= BCD_MAX) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser, debouncer and press-pulse generator
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-low reset
//   btn   in  raw asynchronous button, active-high
//   press out one-cycle pulse on each accepted rising edge of the debounced level
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_1  <= btn;
      sync_2  <= sync_1;
      level_d <= level;
      press   <= level & ~level_d;
      // cnt holds how many consecutive cycles sync_2 has disagreed with level;
      // the DB_CYCLES-th disagreeing cycle flips level.
      if (sync_2 != level) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch FSM, prescaler, BCD time counter and lap bank
//
// Ports:
//   clk, rst                    clock and synchronous active-low reset
//   start_btn, lap_btn          raw buttons, active-high
//   run_a..run_d                running time BCD: tens of s, s, tenths, hundredths
//   lap_e..lap_h                captured lap time, same digit order
//   run                         high while in RUN
//   start_press                 one-cycle pulse per accepted start press
//   lap_valid                   lap digits hold a capture
//   overflow                    one-cycle pulse when 99.99 wraps to 00.00
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             lap_btn,
  output logic [BCD_W-1:0] run_a,
  output logic [BCD_W-1:0] run_b,
  output logic [BCD_W-1:0] run_c,
  output logic [BCD_W-1:0] run_d,
  output logic [BCD_W-1:0] lap_e,
  output logic [BCD_W-1:0] lap_f,
  output logic [BCD_W-1:0] lap_g,
  output logic [BCD_W-1:0] lap_h,
  output logic             run,
  output logic             start_press,
  output logic             lap_valid,
  output logic             overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);

  sw_state_e state_q, state_d;
  logic      start_pulse, lap_pulse;
  logic      do_capture, do_clear, clr_valid;
  logic      tick, carry;

  logic [PRE_W-1:0]                  presc_q;
  // Index NUM_DIGITS-1 is the most significant digit (run_a / lap_e).
  logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] lap_q;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_start_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .press (start_pulse)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_lap_cond (
    .clk   (clk),
    .rst   (rst),
    .btn   (lap_btn),
    .press (lap_pulse)
  );

  // Start always wins; a lap press arriving with it is simply ignored.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_clear   = 1'b0;
    clr_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_pulse) begin
          state_d   = ST_PAUSE;
          clr_valid = 1'b1;
        end else if (lap_pulse) begin
          do_capture = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_pulse) begin
          state_d = ST_RUN;
        end else if (lap_pulse) begin
          state_d  = ST_IDLE;
          do_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRE_W'(TICK_DIV - 1));

  // Ripple the tick through the digits; carry out of the top digit is the wrap.
  always_comb begin
    digit_d = digit_q;
    carry   = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        digit_d[i] = bcd_inc(digit_q[i]);
        carry      = (digit_q[i] >= BCD_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      digit_q     <= '0;
      lap_q       <= '0;
      lap_valid   <= 1'b0;
      start_press <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_press <= start_pulse;
      overflow    <= carry;
      if (do_clear) begin
        presc_q   <= '0;
        digit_q   <= '0;
        lap_q     <= '0;
        lap_valid <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN:  presc_q <= tick ? '0 : presc_q + 1'b1;
          ST_IDLE: presc_q <= '0;
          default: presc_q <= presc_q;
        endcase
        digit_q <= digit_d;
        // Capture the pre-tick digits so a lap never sees a half-updated value.
        if (do_capture) begin
          lap_q     <= digit_q;
          lap_valid <= 1'b1;
        end else if (clr_valid) begin
          lap_valid <= 1'b0;
        end
      end
    end
  end

  assign run   = (state_q == ST_RUN);
  assign run_a = digit_q[3];
  assign run_b = digit_q[2];
  assign run_c = digit_q[1];
  assign run_d = digit_q[0];
  assign lap_e = lap_q[3];
  assign lap_f = lap_q[2];
  assign lap_g = lap_q[1];
  assign lap_h = lap_q[0];

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: TICK_DIV = 10, DB_CYCLES = 4
  logic       m_rst, m_start, m_lap;
  logic [3:0] m_a, m_b, m_c, m_d, m_e, m_f, m_g, m_h;
  logic       m_run, m_sp, m_lv, m_ovf;
  logic [15:0] m_time, m_lapt;
  assign m_time = {m_a, m_b, m_c, m_d};
  assign m_lapt = {m_e, m_f, m_g, m_h};

  // Fast instance: TICK_DIV = 2, DB_CYCLES = 1, used for long-count cases
  logic       f_rst, f_start, f_lap;
  logic [3:0] f_a, f_b, f_c, f_d, f_e, f_f, f_g, f_h;
  logic       f_run, f_sp, f_lv, f_ovf;
  logic [15:0] f_time, f_lapt;
  assign f_time = {f_a, f_b, f_c, f_d};
  assign f_lapt = {f_e, f_f, f_g, f_h};

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(4)) u_dut (
    .clk(clk), .rst(m_rst), .start_btn(m_start), .lap_btn(m_lap),
    .run_a(m_a), .run_b(m_b), .run_c(m_c), .run_d(m_d),
    .lap_e(m_e), .lap_f(m_f), .lap_g(m_g), .lap_h(m_h),
    .run(m_run), .start_press(m_sp), .lap_valid(m_lv), .overflow(m_ovf)
  );

  stopwatch_core #(.CLK_HZ(200), .TICK_HZ(100), .DB_CYCLES(1)) u_fast (
    .clk(clk), .rst(f_rst), .start_btn(f_start), .lap_btn(f_lap),
    .run_a(f_a), .run_b(f_b), .run_c(f_c), .run_d(f_d),
    .lap_e(f_e), .lap_f(f_f), .lap_g(f_g), .lap_h(f_h),
    .run(f_run), .start_press(f_sp), .lap_valid(f_lv), .overflow(f_ovf)
  );

  int checks = 0;
  int errors = 0;
  int m_sp_cnt = 0;
  int f_ovf_cnt = 0;
  int sp_before = 0;

  always @(negedge clk) begin
    if (m_sp) m_sp_cnt++;
    if (f_ovf) f_ovf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Main: button edge -> pulse after 7 edges, state change on edge 8.
  task automatic m_press(input logic s, input logic l);
    m_start = s;
    m_lap   = l;
    step(8);
    m_start = 1'b0;
    m_lap   = 1'b0;
  endtask

  // Fast (DB_CYCLES=1): pulse after 4 edges, state change on edge 5.
  task automatic f_press();
    f_start = 1'b1;
    step(5);
    f_start = 1'b0;
  endtask

  initial begin
    m_rst = 1'b0; m_start = 1'b0; m_lap = 1'b0;
    f_rst = 1'b0; f_start = 1'b0; f_lap = 1'b0;
    step(3);
    check_eq("rst_time",  m_time, 16'h0000);
    check_eq("rst_lap",   m_lapt, 16'h0000);
    check_eq("rst_flags", {m_run, m_sp, m_lv, m_ovf}, 4'b0000);
    check_eq("rst_fast",  {f_time, f_run, f_ovf}, 18'h0);
    m_rst = 1'b1;
    f_rst = 1'b1;
    step(2);

    // Start press; n counts edges since run rose
    m_press(1'b1, 1'b0);
    check_eq("start_run",      m_run, 1'b1);
    check_eq("start_pulse_at", m_sp, 1'b1);
    check_eq("start_no_early", m_sp_cnt, 0);
    step(1);                                   // n=1
    check_eq("start_pulse_w",  m_sp, 1'b0);
    check_eq("start_pulse_n",  m_sp_cnt, 1);
    step(369);                                 // n=370
    check_eq("count_0037", m_time, 16'h0037);

    // Lap at 01.25: pressed at n=1248, captured on edge 1256 from digits of n=1255
    step(878);
    m_press(1'b0, 1'b1);                       // n=1256
    check_eq("lap_capture", m_lapt, 16'h0125);
    check_eq("lap_valid",   m_lv, 1'b1);
    step(14);                                  // n=1270
    check_eq("lap_keeps_run", m_time, 16'h0127);
    check_eq("lap_held",      m_lapt, 16'h0125);

    m_press(1'b1, 1'b0);                       // PAUSE on edge n=1278
    check_eq("pause_run",   m_run, 1'b0);
    check_eq("pause_lv",    m_lv, 1'b0);
    check_eq("pause_lap",   m_lapt, 16'h0125);
    check_eq("pause_time",  m_time, 16'h0127);
    step(50);
    check_eq("pause_frozen", m_time, 16'h0127);

    m_press(1'b0, 1'b1);                       // PAUSE + lap -> IDLE
    check_eq("clear_time",  m_time, 16'h0000);
    check_eq("clear_lap",   m_lapt, 16'h0000);
    check_eq("clear_flags", {m_run, m_lv}, 2'b00);
    step(10);

    // Glitch: 3 cycles is one short of the debounce window
    sp_before = m_sp_cnt;
    m_start = 1'b1; step(3); m_start = 1'b0; step(12);
    check_eq("glitch_no_pulse", m_sp_cnt, sp_before);
    check_eq("glitch_idle",     m_run, 1'b0);
    m_start = 1'b1; step(4); m_start = 1'b0; step(10);   // run rose at edge 8 -> n=6
    check_eq("stable_one_pulse", m_sp_cnt, sp_before + 1);
    check_eq("stable_run",       m_run, 1'b1);

    // Capture 00.01 (pressed n=6, captured from n=13), then start+lap together at n=24
    m_press(1'b0, 1'b1);                       // n=14
    step(10);                                  // n=24
    check_eq("lap2_capture", m_lapt, 16'h0001);
    check_eq("lap2_valid",   m_lv, 1'b1);
    m_press(1'b1, 1'b1);                       // PAUSE on edge n=32
    check_eq("both_pause",   m_run, 1'b0);
    check_eq("both_lap",     m_lapt, 16'h0001);
    check_eq("both_lv",      m_lv, 1'b0);
    check_eq("both_time",    m_time, 16'h0003);

    // Fast instance: reset at 42.07 while running
    f_press();                                 // n=0
    check_eq("f_run", f_run, 1'b1);
    step(8414);
    check_eq("f_4207", f_time, 16'h4207);
    f_rst = 1'b0;
    step(1);
    check_eq("f_rst_time",  f_time, 16'h0000);
    check_eq("f_rst_lap",   f_lapt, 16'h0000);
    check_eq("f_rst_flags", {f_run, f_sp, f_lv, f_ovf}, 4'b0000);
    f_rst = 1'b1;
    step(4);
    check_eq("f_idle_hold", f_time, 16'h0000);
    f_press();                                 // n=0
    step(20);
    check_eq("f_restart_0010", f_time, 16'h0010);

    // Run up to 99.99 and across the wrap
    step(19978);                               // n=19998
    check_eq("f_9999",     f_time, 16'h9999);
    check_eq("f_no_ovf",   f_ovf_cnt, 0);
    step(1);                                   // n=19999
    check_eq("f_9999_b",   {f_time, f_ovf}, {16'h9999, 1'b0});
    step(1);                                   // n=20000
    check_eq("f_wrap_time", f_time, 16'h0000);
    check_eq("f_wrap_ovf",  f_ovf, 1'b1);
    step(1);
    check_eq("f_ovf_width", f_ovf, 1'b0);
    check_eq("f_after_wrap", f_time, 16'h0000);
    check_eq("f_ovf_count", f_ovf_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
